pong_match_controller: RTL and testbench
========================================

Name: pong_match_controller

Overview:
Top-level match sequencer for the Pong datapath. It gates ball motion, picks serve direction, keeps per-player scores, pauses and resumes play, and detects game over. It sits in pong_game between the VGA end-of-frame pulse, the ball movement/collision logic, and the score display and sound blocks. All state updates are synchronous to clk50M; frame-rate decisions are qualified by frame_tick.

Parameters:
WIN_SCORE, 7, score that ends the match (1..15)
SERVE_FRAMES, 60, frames the ball is held before a serve (1..255)
POINT_FRAMES, 30, frames of hold after a point is scored (1..255)

Ports:
clk50M  input  1  system clock, 50 MHz
reset  input  1  asynchronous, active-high; clock clk50M
frame_tick  input  1  one-cycle pulse in clk50M domain, once per frame (end of visible area)
start  input  1  start/pause button level, already debounced, synchronous to clk50M
hit  input  1  ball-paddle collision level from ball movement logic
miss_left  input  1  ball reached left border (player one missed)
miss_right  input  1  ball reached right border (player two missed)
ball_hold  output  1  1 = ball movement frozen and re-centred
serve_dir  output  1  0 = serve toward player two (right), 1 = toward player one (left)
score_one  output  4  player one score
score_two  output  4  player two score
state  output  3  IDLE=0, SERVE=1, PLAY=2, PAUSED=3, POINT=4, GAME_OVER=5
game_over  output  1  1 while in GAME_OVER
winner  output  1  0 = player one, 1 = player two; valid only while game_over=1
beep_hit  output  1  one-cycle pulse on a paddle hit
beep_score  output  1  one-cycle pulse when a point is scored

Behaviour:
- Reset (async): state=IDLE, scores=0, serve_dir=0, winner=0, frame_cnt=0, beep pulses=0, ball_hold=1. The start edge register resets to 1, so a button held through reset does not register as a press.
- start_edge = start & ~start_q, where start_q is registered every cycle. start_edge acts in the same cycle regardless of frame_tick.
- ball_hold = 1 in every state except PLAY. game_over = (state==GAME_OVER).
- frame_cnt is 8 bits. It is cleared on every state entry and incremented only on frame_tick in SERVE and POINT.
- IDLE: on start_edge, go to SERVE with serve_dir=0 and scores=0.
- SERVE: on frame_tick with frame_cnt==SERVE_FRAMES-1, go to PLAY; otherwise increment frame_cnt. start_edge is ignored.
- PLAY, evaluated on frame_tick only:
  - miss_left & ~miss_right: score_two+1, serve_dir=1, beep_score, go to POINT.
  - miss_right & ~miss_left: score_one+1, serve_dir=0, beep_score, go to POINT.
  - Both misses in the same tick: no score, serve_dir unchanged, no beep, go to SERVE (replay).
  - Otherwise, if hit: beep_hit pulse.
  - Misses and hit outside frame_tick are ignored.
- PLAY to PAUSED: on start_edge. This has priority over frame_tick in the same cycle, so no scoring is evaluated.
- PAUSED to PLAY: on start_edge. Misses and hit are ignored while paused.
- POINT: on frame_tick with frame_cnt==POINT_FRAMES-1:
  - If score_one==WIN_SCORE, go to GAME_OVER with winner=0.
  - Else if score_two==WIN_SCORE, go to GAME_OVER with winner=1.
  - Else go to SERVE.
  - Otherwise increment frame_cnt.
- Scores saturate at 15; they never wrap.
- GAME_OVER: scores and winner are held. On start_edge: scores=0, serve_dir=0, go to SERVE.
- Outputs are registered; state changes are visible the cycle after the qualifying edge. Beep pulses are exactly one clk50M cycle wide, in the cycle after the qualifying frame_tick.
- Reset asserted mid-match returns everything to IDLE immediately (asynchronously); no partial score survives.

Test Plan:
- Reset with start held high, release, then one start pulse -> state stays IDLE until the pulse, then SERVE; ball_hold=1; scores 0/0.
- From SERVE, apply 60 frame_ticks -> PLAY entered after the 60th tick, ball_hold=0; after 59 ticks state is still SERVE.
- In PLAY: miss_left on a frame_tick -> score_two=1, serve_dir=1, one-cycle beep_score, POINT; after 30 frame_ticks -> SERVE. Miss asserted without frame_tick -> no effect.
- In PLAY: miss_left and miss_right on the same frame_tick -> scores unchanged, state SERVE, no beep; hit on a frame_tick -> single beep_hit pulse.
- In PLAY: start pulse coincident with frame_tick and miss_right -> PAUSED, score_one unchanged, ball_hold=1. Second start pulse -> PLAY.
- Player one scores 7 points (WIN_SCORE=7) -> after the POINT hold: GAME_OVER, winner=0, score_one=7. Start pulse -> scores 0/0, SERVE, serve_dir=0. Async reset mid-POINT -> IDLE immediately.

Source files
------------

// File: rtl/pong_match_if.sv
// Bundle between the Pong match controller and the game datapath.
// The datapath side drives the events, and the controller drives the match status.
interface pong_match_if;
    logic       frame_tick;
    logic       start;
    logic       hit;
    logic       miss_left;
    logic       miss_right;
    logic       ball_hold;
    logic       serve_dir;
    logic [3:0] score_one;
    logic [3:0] score_two;
    logic [2:0] state;
    logic       game_over;
    logic       winner;
    logic       beep_hit;
    logic       beep_score;

    modport master (
        output frame_tick, start, hit, miss_left, miss_right,
        input  ball_hold, serve_dir, score_one, score_two, state,
               game_over, winner, beep_hit, beep_score
    );

    modport slave (
        input  frame_tick, start, hit, miss_left, miss_right,
        output ball_hold, serve_dir, score_one, score_two, state,
               game_over, winner, beep_hit, beep_score
    );
endinterface

// File: rtl/pong_match_controller.sv
// Pong match sequencer: handles serve hold, scoring, pause/resume, and game-over detection.
// Every output is registered, and frame-rate decisions are qualified by frame_tick.
module pong_match_controller #(
    parameter int WIN_SCORE    = 7,
    parameter int SERVE_FRAMES = 60,
    parameter int POINT_FRAMES = 30
) (
    input  logic             clk50M,
    input  logic             reset,
    pong_match_if.slave      bus
);
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SERVE     = 3'd1,
        PLAY      = 3'd2,
        PAUSED    = 3'd3,
        POINT     = 3'd4,
        GAME_OVER = 3'd5
    } state_t;

    localparam logic [7:0] SERVE_LAST = 8'(SERVE_FRAMES - 1);
    localparam logic [7:0] POINT_LAST = 8'(POINT_FRAMES - 1);
    localparam logic [3:0] WIN        = 4'(WIN_SCORE);

    state_t     state_q, state_d;
    logic [3:0] score_one_q, score_one_d, score_two_q, score_two_d;
    logic [7:0] frame_cnt_q, frame_cnt_d;
    logic       serve_dir_q, serve_dir_d;
    logic       winner_q, winner_d;
    logic       beep_hit_q, beep_hit_d, beep_score_q, beep_score_d;
    logic       ball_hold_q, game_over_q;
    logic       start_q;
    logic       start_edge;

    function automatic logic [3:0] sat_inc(input logic [3:0] s);
        return (s == 4'd15) ? 4'd15 : s + 4'd1;
    endfunction

    assign start_edge = bus.start & ~start_q;

    always_comb begin
        state_d      = state_q;
        score_one_d  = score_one_q;
        score_two_d  = score_two_q;
        frame_cnt_d  = frame_cnt_q;
        serve_dir_d  = serve_dir_q;
        winner_d     = winner_q;
        beep_hit_d   = 1'b0;
        beep_score_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_edge) begin
                    state_d     = SERVE;
                    serve_dir_d = 1'b0;
                    score_one_d = 4'd0;
                    score_two_d = 4'd0;
                end
            end
            SERVE: begin
                if (bus.frame_tick) begin
                    if (frame_cnt_q == SERVE_LAST) state_d = PLAY;
                    else frame_cnt_d = frame_cnt_q + 8'd1;
                end
            end
            PLAY: begin
                // A pause press wins over a coincident frame, so that frame is never scored.
                if (start_edge) begin
                    state_d = PAUSED;
                end else if (bus.frame_tick) begin
                    if (bus.miss_left && !bus.miss_right) begin
                        score_two_d  = sat_inc(score_two_q);
                        serve_dir_d  = 1'b1;
                        beep_score_d = 1'b1;
                        state_d      = POINT;
                    end else if (bus.miss_right && !bus.miss_left) begin
                        score_one_d  = sat_inc(score_one_q);
                        serve_dir_d  = 1'b0;
                        beep_score_d = 1'b1;
                        state_d      = POINT;
                    end else if (bus.miss_left && bus.miss_right) begin
                        state_d = SERVE;
                    end else if (bus.hit) begin
                        beep_hit_d = 1'b1;
                    end
                end
            end
            PAUSED: begin
                if (start_edge) state_d = PLAY;
            end
            POINT: begin
                if (bus.frame_tick) begin
                    if (frame_cnt_q == POINT_LAST) begin
                        if (score_one_q == WIN) begin
                            state_d  = GAME_OVER;
                            winner_d = 1'b0;
                        end else if (score_two_q == WIN) begin
                            state_d  = GAME_OVER;
                            winner_d = 1'b1;
                        end else begin
                            state_d = SERVE;
                        end
                    end else begin
                        frame_cnt_d = frame_cnt_q + 8'd1;
                    end
                end
            end
            GAME_OVER: begin
                if (start_edge) begin
                    score_one_d = 4'd0;
                    score_two_d = 4'd0;
                    serve_dir_d = 1'b0;
                    state_d     = SERVE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Entering any state, including a replay into SERVE from PLAY, restarts the frame count.
        if (state_d != state_q) frame_cnt_d = 8'd0;
    end

    always_ff @(posedge clk50M or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            score_one_q  <= 4'd0;
            score_two_q  <= 4'd0;
            frame_cnt_q  <= 8'd0;
            serve_dir_q  <= 1'b0;
            winner_q     <= 1'b0;
            beep_hit_q   <= 1'b0;
            beep_score_q <= 1'b0;
            ball_hold_q  <= 1'b1;
            game_over_q  <= 1'b0;
            start_q      <= 1'b1;
        end else begin
            state_q      <= state_d;
            score_one_q  <= score_one_d;
            score_two_q  <= score_two_d;
            frame_cnt_q  <= frame_cnt_d;
            serve_dir_q  <= serve_dir_d;
            winner_q     <= winner_d;
            beep_hit_q   <= beep_hit_d;
            beep_score_q <= beep_score_d;
            ball_hold_q  <= (state_d != PLAY);
            game_over_q  <= (state_d == GAME_OVER);
            start_q      <= bus.start;
        end
    end

    assign bus.state      = state_q;
    assign bus.score_one  = score_one_q;
    assign bus.score_two  = score_two_q;
    assign bus.serve_dir  = serve_dir_q;
    assign bus.winner     = winner_q;
    assign bus.ball_hold  = ball_hold_q;
    assign bus.game_over  = game_over_q;
    assign bus.beep_hit   = beep_hit_q;
    assign bus.beep_score = beep_score_q;
endmodule

// File: tb/tb_pong_match_controller.sv
// Directed bench for pong_match_controller, using a scoreboard queue of expected snapshots and beep counts.
module tb_pong_match_controller;
    logic clk50M = 1'b0;
    logic reset  = 1'b1;
    pong_match_if bus();

    pong_match_controller dut (
        .clk50M (clk50M),
        .reset  (reset),
        .bus    (bus)
    );

    always #5 clk50M = ~clk50M;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   total  = 0;
    int   passed = 0;
    int   hit_beeps   = 0;
    int   score_beeps = 0;
    int   hit_base, score_base;

    // Count high cycles of each beep, which exposes both missing pulses and over-long pulses.
    always @(posedge clk50M) begin
        if (bus.beep_hit)   hit_beeps   <= hit_beeps + 1;
        if (bus.beep_score) score_beeps <= score_beeps + 1;
    end

    function automatic logic [31:0] snap();
        return {17'd0, bus.state, bus.score_one, bus.score_two,
                bus.serve_dir, bus.ball_hold, bus.game_over, bus.winner};
    endfunction

    function automatic logic [31:0] mk(input int st, input int s1, input int s2,
                                       input bit dir, input bit hold, input bit go, input bit win);
        return {17'd0, 3'(st), 4'(s1), 4'(s2), dir, hold, go, win};
    endfunction

    task automatic push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        exp_q.push_back(e);
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t e;
        if (exp_q.size() == 0) begin
            total++;
            $error("FAIL scoreboard_empty got=%h want=<queued entry>", obs);
            return;
        end
        e = exp_q.pop_front();
        total++;
        assert (obs === e.val) passed++;
        else $error("FAIL %s got=%h want=%h", e.tag, obs, e.val);
    endtask

    task automatic expect_snap(input string tag, input logic [31:0] v);
        push(tag, v);
        check(snap());
    endtask

    task automatic cyc();
        @(posedge clk50M);
        #1;
    endtask

    task automatic frame();
        bus.frame_tick = 1'b1;
        cyc();
        bus.frame_tick = 1'b0;
        cyc();
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) frame();
    endtask

    task automatic press();
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
        cyc();
    endtask

    initial begin
        bus.frame_tick = 1'b0;
        bus.start      = 1'b1;
        bus.hit        = 1'b0;
        bus.miss_left  = 1'b0;
        bus.miss_right = 1'b0;
        repeat (3) cyc();
        expect_snap("reset_state", mk(0, 0, 0, 0, 1, 0, 0));

        // Start is held through the reset release, so it must not count as a press.
        reset = 1'b0;
        repeat (3) cyc();
        expect_snap("held_start_no_press", mk(0, 0, 0, 0, 1, 0, 0));
        bus.start = 1'b0;
        cyc();
        expect_snap("idle_before_press", mk(0, 0, 0, 0, 1, 0, 0));
        press();
        expect_snap("serve_after_press", mk(1, 0, 0, 0, 1, 0, 0));

        frames(30);
        press();
        frames(29);
        expect_snap("serve_after_59", mk(1, 0, 0, 0, 1, 0, 0));
        frame();
        expect_snap("play_after_60", mk(2, 0, 0, 0, 0, 0, 0));

        bus.miss_left = 1'b1;
        repeat (2) cyc();
        bus.miss_left = 1'b0;
        expect_snap("miss_no_tick", mk(2, 0, 0, 0, 0, 0, 0));

        score_base = score_beeps;
        push("beep_score_left", 32'd1);
        bus.miss_left = 1'b1;
        frame();
        bus.miss_left = 1'b0;
        check(32'(score_beeps - score_base));
        expect_snap("point_left", mk(4, 0, 1, 1, 1, 0, 0));
        frames(29);
        expect_snap("point_hold_29", mk(4, 0, 1, 1, 1, 0, 0));
        frame();
        expect_snap("serve_after_point", mk(1, 0, 1, 1, 1, 0, 0));
        frames(60);

        score_base = score_beeps;
        push("beep_score_double", 32'd0);
        bus.miss_left  = 1'b1;
        bus.miss_right = 1'b1;
        frame();
        bus.miss_left  = 1'b0;
        bus.miss_right = 1'b0;
        check(32'(score_beeps - score_base));
        expect_snap("double_miss_replay", mk(1, 0, 1, 1, 1, 0, 0));
        frames(60);
        expect_snap("play_again", mk(2, 0, 1, 1, 0, 0, 0));

        hit_base = hit_beeps;
        push("beep_hit_tick", 32'd1);
        bus.hit = 1'b1;
        frame();
        repeat (3) cyc();
        bus.hit = 1'b0;
        check(32'(hit_beeps - hit_base));

        bus.start      = 1'b1;
        bus.frame_tick = 1'b1;
        bus.miss_right = 1'b1;
        cyc();
        bus.start      = 1'b0;
        bus.frame_tick = 1'b0;
        cyc();
        expect_snap("pause_priority", mk(3, 0, 1, 1, 1, 0, 0));
        frame();
        bus.miss_right = 1'b0;
        expect_snap("paused_ignores_miss", mk(3, 0, 1, 1, 1, 0, 0));
        press();
        expect_snap("resume_play", mk(2, 0, 1, 1, 0, 0, 0));

        for (int k = 1; k <= 7; k++) begin
            bus.miss_right = 1'b1;
            frame();
            bus.miss_right = 1'b0;
            expect_snap($sformatf("point_right_%0d", k), mk(4, k, 1, 0, 1, 0, 0));
            frames(30);
            if (k < 7) frames(60);
        end
        expect_snap("game_over_p1", mk(5, 7, 1, 0, 1, 1, 0));
        frames(5);
        expect_snap("game_over_held", mk(5, 7, 1, 0, 1, 1, 0));
        press();
        expect_snap("restart_serve", mk(1, 0, 0, 0, 1, 0, 0));

        frames(60);
        bus.miss_right = 1'b1;
        frame();
        bus.miss_right = 1'b0;
        frames(3);
        expect_snap("point_before_reset", mk(4, 1, 0, 0, 1, 0, 0));
        reset = 1'b1;
        #2;
        expect_snap("async_reset_mid_point", mk(0, 0, 0, 0, 1, 0, 0));
        cyc();
        reset = 1'b0;
        cyc();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got=running want=finished");
        $fatal(1, "timeout");
    end
endmodule
